// File: rtl/console_io_pkg.sv
// console_io_pkg: shared UART state type, PS/2 control codes and Set-2 scancode to ASCII lookup
package console_io_pkg;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  // returns {mapped, ascii}; letters derive their shifted form by case flip
  function automatic logic [8:0] ps2_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] u, s;
    u = 8'h00;
    s = 8'h00;
    case (code)
      8'h1C: u = "a";  8'h32: u = "b";  8'h21: u = "c";  8'h23: u = "d";
      8'h24: u = "e";  8'h2B: u = "f";  8'h34: u = "g";  8'h33: u = "h";
      8'h43: u = "i";  8'h3B: u = "j";  8'h42: u = "k";  8'h4B: u = "l";
      8'h3A: u = "m";  8'h31: u = "n";  8'h44: u = "o";  8'h4D: u = "p";
      8'h15: u = "q";  8'h2D: u = "r";  8'h1B: u = "s";  8'h2C: u = "t";
      8'h3C: u = "u";  8'h2A: u = "v";  8'h1D: u = "w";  8'h22: u = "x";
      8'h35: u = "y";  8'h1A: u = "z";
      8'h45: {u, s} = {"0", ")"};  8'h16: {u, s} = {"1", "!"};
      8'h1E: {u, s} = {"2", "@"};  8'h26: {u, s} = {"3", "#"};
      8'h25: {u, s} = {"4", "$"};  8'h2E: {u, s} = {"5", "%"};
      8'h36: {u, s} = {"6", "^"};  8'h3D: {u, s} = {"7", "&"};
      8'h3E: {u, s} = {"8", "*"};  8'h46: {u, s} = {"9", "("};
      8'h4E: {u, s} = {"-", "_"};  8'h55: {u, s} = {"=", "+"};
      8'h41: {u, s} = {",", "<"};  8'h49: {u, s} = {".", ">"};
      8'h4A: {u, s} = {"/", "?"};  8'h4C: {u, s} = {";", ":"};
      8'h52: {u, s} = {8'h27, 8'h22};
      8'h29: u = 8'h20;  8'h5A: u = 8'h0D;  8'h66: u = 8'h08;  8'h76: u = 8'h1B;
      default: ;
    endcase
    if (s == 8'h00) s = (u >= "a" && u <= "z") ? u - 8'h20 : u;
    return {u != 8'h00, shift ? s : u};
  endfunction
endpackage

// File: rtl/console_io_uart.sv
// uart_core: 8N1 UART transmitter and mid-bit sampling receiver
module uart_core
  import console_io_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       srx,
  output logic       stx,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       rx_rd
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  logic tx_busy_q, tx_busy_d, stx_q, stx_d;
  logic [9:0] tx_sr_q, tx_sr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic srx_m_q, srx_m_d, srx_s_q, srx_s_d, srx_p_q, srx_p_d;
  uart_state_t rx_st_q, rx_st_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic rx_rdy_q, rx_rdy_d;
  assign stx = stx_q;
  assign tx_busy = tx_busy_q;
  assign rx_data = rx_data_q;
  assign rx_rdy = rx_rdy_q;
  // transmitter: a 10-bit frame shifts out one bit per CLK_DIV cycles; stx is registered from the next state
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sr_d = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    if (!tx_busy_q) begin
      if (tx_en) begin
        tx_busy_d = 1'b1;
        tx_sr_d = {1'b1, tx_data, 1'b0};
        tx_cnt_d = '0;
        tx_bit_d = '0;
      end
    end else if (tx_cnt_q == BIT_END) begin
      tx_cnt_d = '0;
      tx_sr_d = {1'b1, tx_sr_q[9:1]};
      tx_bit_d = tx_bit_q + 4'd1;
      if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
    end else tx_cnt_d = tx_cnt_q + 1'b1;
    stx_d = tx_busy_d ? tx_sr_d[0] : 1'b1;
  end
  // receiver: start edge, half-bit glitch recheck, 8 mid-bit data samples, stop check; a new byte beats rx_rd
  always_comb begin
    srx_m_d = srx;
    srx_s_d = srx_m_q;
    srx_p_d = srx_s_q;
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sr_d = rx_sr_q;
    rx_data_d = rx_data_q;
    rx_rdy_d = rx_rdy_q & ~rx_rd;
    case (rx_st_q)
      U_IDLE: begin
        rx_cnt_d = '0;
        if (srx_p_q && !srx_s_q) rx_st_d = U_START;
      end
      U_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = srx_s_q ? U_IDLE : U_DATA;
      end
      U_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sr_d = {srx_s_q, rx_sr_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = U_STOP;
      end
      default: if (rx_cnt_q == BIT_END) begin
        rx_st_d = U_IDLE;
        if (srx_s_q) begin
          rx_data_d = rx_sr_q;
          rx_rdy_d = 1'b1;
        end
      end
    endcase
  end
  // state registers; line synchronizers reset to the idle-high level
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tx_busy_q <= 1'b0;
      stx_q <= 1'b1;
      tx_sr_q <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      srx_m_q <= 1'b1;
      srx_s_q <= 1'b1;
      srx_p_q <= 1'b1;
      rx_st_q <= U_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sr_q <= '0;
      rx_data_q <= '0;
      rx_rdy_q <= 1'b0;
    end else begin
      tx_busy_q <= tx_busy_d;
      stx_q <= stx_d;
      tx_sr_q <= tx_sr_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      srx_m_q <= srx_m_d;
      srx_s_q <= srx_s_d;
      srx_p_q <= srx_p_d;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sr_q <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_rdy_q <= rx_rdy_d;
    end
  end
endmodule

// File: rtl/console_io.sv
// console_io: UART plus PS/2 keyboard receiver with Set-2 to ASCII decode
module console_io
  import console_io_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int PS2_TIMEOUT = 50000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       srx,
  output logic       stx,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       rx_rd,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       ps2_en,
  output logic [7:0] kb_data,
  output logic       kb_rdy,
  input  logic       kb_req
);
  localparam int TW = $clog2(PS2_TIMEOUT + 1);
  logic ps2c_m_q, ps2c_m_d, ps2c_s_q, ps2c_s_d, ps2d_m_q, ps2d_m_d, ps2d_s_q, ps2d_s_d;
  logic ps2c_f_q, ps2c_f_d;
  logic [2:0] flt_cnt_q, flt_cnt_d;
  logic [9:0] ps2_sr_q, ps2_sr_d;
  logic [3:0] ps2_bit_q, ps2_bit_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic brk_q, brk_d, shift_q, shift_d, kb_rdy_q, kb_rdy_d;
  logic [7:0] kb_data_q, kb_data_d, code;
  logic flip, fall;
  logic [10:0] frame;
  logic [8:0] map;
  uart_core #(.CLK_DIV(CLK_DIV)) u_uart (
    .CLOCK(CLOCK), .RESET(RESET), .srx(srx), .stx(stx),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rd(rx_rd)
  );
  assign kb_data = kb_data_q;
  assign kb_rdy = kb_rdy_q;
  // synchronize and deglitch PS/2 clock, shift frames on its falling edge, decode accepted codes
  always_comb begin
    ps2c_m_d = ps2c;
    ps2c_s_d = ps2c_m_q;
    ps2d_m_d = ps2d;
    ps2d_s_d = ps2d_m_q;
    flip = (ps2c_s_q != ps2c_f_q) && flt_cnt_q == 3'd7;
    flt_cnt_d = (ps2c_s_q == ps2c_f_q || flip) ? 3'd0 : flt_cnt_q + 3'd1;
    ps2c_f_d = flip ? ps2c_s_q : ps2c_f_q;
    fall = flip && ps2c_f_q;
    frame = {ps2d_s_q, ps2_sr_q};
    code = frame[8:1];
    map = ps2_ascii(code, shift_q);
    ps2_sr_d = ps2_sr_q;
    ps2_bit_d = ps2_bit_q;
    to_cnt_d = to_cnt_q;
    brk_d = brk_q;
    shift_d = shift_q;
    kb_data_d = kb_data_q;
    kb_rdy_d = kb_rdy_q & ~kb_req;
    if (!ps2_en) begin
      ps2_bit_d = '0;
      to_cnt_d = '0;
    end else if (fall) begin
      to_cnt_d = '0;
      ps2_sr_d = frame[10:1];
      ps2_bit_d = ps2_bit_q + 4'd1;
      if (ps2_bit_q == 4'd10) begin
        ps2_bit_d = '0;
        if (!frame[0] && frame[10] && ^frame[9:1]) begin
          if (code == PS2_BREAK) brk_d = 1'b1;
          else if (code != PS2_EXT) begin
            if (code == PS2_LSHIFT || code == PS2_RSHIFT) begin
              shift_d = ~brk_q;
              brk_d = 1'b0;
            end else if (brk_q) brk_d = 1'b0;
            else if (map[8]) begin
              kb_data_d = map[7:0];
              kb_rdy_d = 1'b1;
            end
          end
        end
      end
    end else if (ps2_bit_q != 4'd0) begin
      if (to_cnt_q == TW'(PS2_TIMEOUT - 1)) begin
        ps2_bit_d = '0;
        to_cnt_d = '0;
      end else to_cnt_d = to_cnt_q + 1'b1;
    end
  end
  // PS/2 state registers; lines and filter reset to idle-high
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ps2c_m_q <= 1'b1;
      ps2c_s_q <= 1'b1;
      ps2d_m_q <= 1'b1;
      ps2d_s_q <= 1'b1;
      ps2c_f_q <= 1'b1;
      flt_cnt_q <= '0;
      ps2_sr_q <= '0;
      ps2_bit_q <= '0;
      to_cnt_q <= '0;
      brk_q <= 1'b0;
      shift_q <= 1'b0;
      kb_data_q <= '0;
      kb_rdy_q <= 1'b0;
    end else begin
      ps2c_m_q <= ps2c_m_d;
      ps2c_s_q <= ps2c_s_d;
      ps2d_m_q <= ps2d_m_d;
      ps2d_s_q <= ps2d_s_d;
      ps2c_f_q <= ps2c_f_d;
      flt_cnt_q <= flt_cnt_d;
      ps2_sr_q <= ps2_sr_d;
      ps2_bit_q <= ps2_bit_d;
      to_cnt_q <= to_cnt_d;
      brk_q <= brk_d;
      shift_q <= shift_d;
      kb_data_q <= kb_data_d;
      kb_rdy_q <= kb_rdy_d;
    end
  end
endmodule

// File: tb/tb_console_io.sv
// tb_console_io: directed scoreboard bench for the UART and PS/2 keyboard paths
module tb_console_io;
  localparam int CLK_DIV = 16;
  localparam int PS2_TIMEOUT = 1000;
  logic CLOCK = 1'b0, RESET = 1'b1, srx = 1'b1, tx_en = 1'b0, rx_rd = 1'b0;
  logic ps2c = 1'b1, ps2d = 1'b1, ps2_en = 1'b1, kb_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic stx, tx_busy, rx_rdy, kb_rdy;
  logic [7:0] rx_data, kb_data;
  int checks = 0, errors = 0;
  logic [7:0] rx_q[$], kb_q[$];
  logic tx_q[$];
  console_io #(.CLK_DIV(CLK_DIV), .PS2_TIMEOUT(PS2_TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .srx(srx), .stx(stx), .tx_data(tx_data),
    .tx_en(tx_en), .tx_busy(tx_busy), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_rd(rx_rd), .ps2c(ps2c), .ps2d(ps2d), .ps2_en(ps2_en),
    .kb_data(kb_data), .kb_rdy(kb_rdy), .kb_req(kb_req)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_uart(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      srx = f[i];
      tick(CLK_DIV);
    end
    srx = 1'b1;
  endtask
  task automatic send_ps2(input logic [7:0] code, input logic bad, input int n);
    logic [10:0] f;
    f = {1'b1, (~(^code)) ^ bad, code, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      tick(10);
      ps2c = 1'b0;
      tick(20);
      ps2c = 1'b1;
      tick(10);
    end
    ps2d = 1'b1;
  endtask
  task automatic get_rx(input string tag);
    for (int i = 0; i < 4 * CLK_DIV && rx_rdy !== 1'b1; i++) tick(1);
    check({tag, "_rdy"}, 8'(rx_rdy), 8'd1);
    check(tag, rx_data, rx_q.pop_front());
  endtask
  task automatic get_kb(input string tag);
    for (int i = 0; i < 200 && kb_rdy !== 1'b1; i++) tick(1);
    check({tag, "_rdy"}, 8'(kb_rdy), 8'd1);
    check(tag, kb_data, kb_q.pop_front());
  endtask
  task automatic clear_kb(input string tag);
    kb_req = 1'b1;
    tick(1);
    kb_req = 1'b0;
    check(tag, 8'(kb_rdy), 8'd0);
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_stx"}, 8'(stx), 8'd1);
    check({tag, "_busy"}, 8'(tx_busy), 8'd0);
    check({tag, "_rxd"}, rx_data, 8'h00);
    check({tag, "_rxr"}, 8'(rx_rdy), 8'd0);
    check({tag, "_kbd"}, kb_data, 8'h00);
    check({tag, "_kbr"}, 8'(kb_rdy), 8'd0);
  endtask
  initial begin
    logic [9:0] tf;
    tick(3);
    RESET = 1'b0;
    tick(1);
    reset_checks("rst");
    tx_data = 8'h55;
    tx_en = 1'b1;
    tf = {1'b1, tx_data, 1'b0};
    for (int i = 0; i < 10; i++) tx_q.push_back(tf[i]);
    tick(1);
    tx_en = 1'b0;
    check("tx_busy_set", 8'(tx_busy), 8'd1);
    tick(CLK_DIV / 2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), 8'(stx), 8'(tx_q.pop_front()));
      if (i < 9) tick(CLK_DIV);
    end
    tick(CLK_DIV / 2 - 1);
    check("tx_busy_hold", 8'(tx_busy), 8'd1);
    tick(1);
    check("tx_busy_end", 8'(tx_busy), 8'd0);
    tick(5);
    send_uart(8'hA5, 1'b1);
    get_rx("rx_a5");
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
    check("rx_rd_clr", 8'(rx_rdy), 8'd0);
    check("rx_hold", rx_data, 8'hA5);
    srx = 1'b0;
    tick(4);
    srx = 1'b1;
    tick(3 * CLK_DIV);
    check("rx_glitch", 8'(rx_rdy), 8'd0);
    send_uart(8'h3C, 1'b0);
    tick(2 * CLK_DIV);
    check("rx_frm_rdy", 8'(rx_rdy), 8'd0);
    check("rx_frm_data", rx_data, 8'hA5);
    send_uart(8'h11, 1'b1);
    get_rx("rx_11");
    send_uart(8'h22, 1'b1);
    get_rx("rx_overrun");
    kb_q.push_back(8'h61);
    send_ps2(8'h1C, 1'b0, 11);
    get_kb("kb_a");
    clear_kb("kb_clr_a");
    send_ps2(8'hF0, 1'b0, 11);
    send_ps2(8'h1C, 1'b0, 11);
    tick(5);
    check("kb_brk_a", 8'(kb_rdy), 8'd0);
    send_ps2(8'h12, 1'b0, 11);
    tick(5);
    check("kb_shift_make", 8'(kb_rdy), 8'd0);
    kb_q.push_back(8'h41);
    send_ps2(8'h1C, 1'b0, 11);
    get_kb("kb_A");
    clear_kb("kb_clr_A");
    send_ps2(8'hF0, 1'b0, 11);
    send_ps2(8'h12, 1'b0, 11);
    tick(5);
    check("kb_shift_brk", 8'(kb_rdy), 8'd0);
    kb_q.push_back(8'h31);
    send_ps2(8'h16, 1'b0, 11);
    get_kb("kb_1");
    clear_kb("kb_clr_1");
    send_ps2(8'h1C, 1'b1, 11);
    tick(20);
    check("kb_parity", 8'(kb_rdy), 8'd0);
    send_ps2(8'h1C, 1'b0, 5);
    tick(PS2_TIMEOUT + 50);
    check("kb_partial", 8'(kb_rdy), 8'd0);
    kb_q.push_back(8'h20);
    send_ps2(8'h29, 1'b0, 11);
    get_kb("kb_timeout_space");
    send_ps2(8'h1C, 1'b0, 4);
    tx_data = 8'hC3;
    tx_en = 1'b1;
    tick(1);
    tx_en = 1'b0;
    srx = 1'b0;
    tick(3 * CLK_DIV);
    RESET = 1'b1;
    srx = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(1);
    reset_checks("rst_mid");
    send_uart(8'h5A, 1'b1);
    get_rx("rx_post_rst");
    kb_q.push_back(8'h30);
    send_ps2(8'h45, 1'b0, 11);
    get_kb("kb_post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/console_io.md
Name: console_io

Overview:
- Console I/O peripheral for the CPU core. It contains a full-duplex 8N1 UART and a PS/2 keyboard receiver that converts Set-2 scancodes to ASCII.
- Each direction presents a byte plus a ready/busy flag with single-cycle request handshakes.
- The CPU reads the UART first and falls back to the keyboard; status is rx_rdy | kb_rdy.

Parameters:
- CLK_DIV, 434, CLOCK cycles per UART bit (50 MHz / 115200); minimum 8.
- PS2_TIMEOUT, 50000, CLOCK cycles without a PS/2 clock edge mid-frame before the frame is abandoned.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high.
- srx  in  1  UART receive line, asynchronous, idle high.
- stx  out  1  UART transmit line, idle high.
- tx_data  in  8  byte to transmit.
- tx_en  in  1  one-cycle start pulse.
- tx_busy  out  1  transmitter busy.
- rx_data  out  8  last received UART byte.
- rx_rdy  out  1  UART byte available.
- rx_rd  in  1  one-cycle pulse; clears rx_rdy.
- ps2c  in  1  PS/2 clock, asynchronous.
- ps2d  in  1  PS/2 data, asynchronous.
- ps2_en  in  1  PS/2 receive enable; while 0 the shift state machine is held idle.
- kb_data  out  8  ASCII code of last key.
- kb_rdy  out  1  key available.
- kb_req  in  1  one-cycle pulse; clears kb_rdy.

Behaviour:
- Reset: RESET, synchronous, active-high; clock CLOCK. After reset stx=1, tx_busy=0, rx_data=0, rx_rdy=0, kb_data=0, kb_rdy=0, shift=0, break flag=0, all bit counters 0.
- Input sync: srx, ps2c and ps2d each pass through 2-FF synchronizers.
- PS/2 clock filter: ps2c must be stable for 8 consecutive cycles before its filtered value changes.
- UART TX start: tx_en while tx_busy=0 latches tx_data and sets tx_busy on the next edge. tx_en while busy is ignored.
- UART TX frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLK_DIV cycles.
- UART TX end: tx_busy drops after the stop-bit period, 10*CLK_DIV cycles after the frame starts. A new tx_en may be issued in the same cycle that tx_busy reads 0.
- UART RX states: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge on synced srx enters START.
  - START: at CLK_DIV/2 srx is re-checked. If it is high, the glitch is ignored and the receiver returns to IDLE.
  - DATA: 8 bits are sampled at CLK_DIV intervals, at mid-bit, LSB first.
  - STOP: the stop bit is sampled. If it is 0 (framing error) the byte is discarded. If it is 1, rx_data is loaded and rx_rdy is set one cycle after the stop sample.
- UART RX overrun: a new byte overwrites rx_data and rx_rdy stays 1. If rx_rd and a byte completion occur in the same cycle, the set wins.
- PS/2 frame: shift on each filtered ps2c falling edge. Frame is 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
  - The frame is discarded on a bad start, parity or stop bit.
  - The frame is discarded if PS2_TIMEOUT cycles pass with no edge while the bit count is nonzero.
- PS/2 decode, per accepted code:
  - 0xF0 sets the break flag.
  - 0xE0 is ignored; the following code is processed as normal.
  - 0x12 or 0x59 sets shift on make and clears shift on break.
  - Any other code with the break flag set clears the break flag and produces no output.
  - Any other code on make is looked up in the ASCII table. Unmapped codes produce no output. A mapped code loads kb_data and sets kb_rdy one cycle after the stop bit.
- ASCII table, unshifted:
  - Letters a–z (for example 0x1C->'a' 0x61, 0x32->'b').
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> '0'..'9'.
  - 0x29->0x20, 0x5A->0x0D, 0x66->0x08, 0x76->0x1B.
  - 0x4E->'-', 0x55->'=', 0x41->',', 0x49->'.', 0x4A->'/', 0x4C->';', 0x52->0x27.
- ASCII table, shifted:
  - Letters become uppercase.
  - Digits 1–9,0 become !@#$%^&*().
  - - = , . / ; ' become _ + < > ? : ".
- kb_rdy clear/overrun: kb_req clears kb_rdy. A simultaneous new key wins; overrun overwrites kb_data.

Decomposition:
- Package console_io_pkg: UART state enum, PS/2 constants (F0, E0, 12, 59) and the scancode->ASCII function (unshifted and shifted).
- Sub-module uart_core: the TX and RX engines.
- PS/2 receive/decode stays in console_io.

Test Plan (bench uses CLK_DIV=16):
- UART TX: pulse tx_en with tx_data=0x55. tx_busy=1 the next cycle. stx carries 0,1,0,1,0,1,0,1,0,1 at 16 cycles per bit, then tx_busy=0 after 160 cycles.
- UART RX: drive frame 0xA5 on srx. rx_data=0xA5 and rx_rdy=1; an rx_rd pulse clears rx_rdy and rx_data holds.
- UART RX errors: a 4-cycle low glitch on srx leaves rx_rdy=0. A frame 0x3C with stop bit 0 leaves rx_rdy=0 and rx_data unchanged.
- PS/2 shift sequence: send 1C, F0 1C, 12, 1C, F0 12, 16.
  - First 1C -> kb_data=0x61, kb_rdy=1; clear it with kb_req.
  - Shifted 1C -> kb_data=0x41.
  - Final 16 -> kb_data=0x31.
  - The break codes produce no kb_rdy.
- PS/2 parity error: code 0x1C with even parity is discarded, kb_rdy stays 0.
- PS/2 timeout: abandon a frame after 5 bits and wait PS2_TIMEOUT cycles; then a valid 0x29 yields kb_data=0x20.
- Reset mid-frame: assert RESET during a UART and a PS/2 frame. All outputs return to their reset values and the next full frames are received correctly.
